// File: rtl/i2c_master.sv
// Byte-level I2C initiator: START / WRITE / READ / STOP executed one command at a time.
// Optional clock stretching is enabled by defining I2C_CLK_STRETCH_EN.
module i2c_master #(
  parameter int unsigned CLK_DIV = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic [7:0] wr_data,
  input  logic       rd_ack,
  output logic [7:0] rd_data,
  output logic       ack_o,
  output logic       done,
  output logic       err,
  output logic       busy,
  input  logic       scl_i,
  output logic       scl_o,
  input  logic       sda_i,
  output logic       sda_o
);

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] CntPre  = CntW'(CLK_DIV - 2);

  localparam logic [1:0] CmdStart = 2'b00;
  localparam logic [1:0] CmdRead  = 2'b10;
  localparam logic [1:0] CmdStop  = 2'b11;

  typedef enum logic [2:0] {StIdle, StStart, StBit, StAck, StStop, StErr} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [1:0]      phase_q;
  logic [2:0]      bit_q;
  logic [7:0]      data_q;
  logic            is_read_q;
  logic            rd_ack_q;
  logic            stall;
  logic            tick;
  logic            pre_done;

`ifdef I2C_CLK_STRETCH_EN
  // Target may hold SCL low after we release it; freeze the quarter timer until it lets go.
  assign stall = (phase_q == 2'd1) && (cnt_q == '0) && !scl_i;
`else
  logic unused_scl_i;
  assign unused_scl_i = scl_i;
  assign stall = 1'b0;
`endif

  assign tick     = (cnt_q == CntLast);
  assign pre_done = (cnt_q == CntPre) && (phase_q == 2'd3) &&
                    ((state_q == StStart) || (state_q == StAck) || (state_q == StStop));

  // Line levels {scl, sda} on entry to quarter ph; bit_val is the SDA level for BIT/ACK q0.
  function automatic logic [1:0] phase_lines(state_e st, logic [1:0] ph, logic scl_cur,
                                             logic sda_cur, logic bit_val);
    logic [1:0] l;
    l = {scl_cur, sda_cur};
    case (st)
      StStart: begin
        case (ph)
          2'd0:    l = {scl_cur, 1'b1};
          2'd1:    l = {1'b1, sda_cur};
          2'd2:    l = 2'b10;
          default: l = 2'b00;
        endcase
      end
      StStop: begin
        case (ph)
          2'd0:    l = 2'b00;
          2'd1:    l = 2'b10;
          default: l = 2'b11;
        endcase
      end
      StBit, StAck: begin
        case (ph)
          2'd0:    l = {1'b0, bit_val};
          2'd1,
          2'd2:    l = {1'b1, sda_cur};
          default: l = {1'b0, sda_cur};
        endcase
      end
      default: l = {scl_cur, sda_cur};
    endcase
    return l;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      phase_q   <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      is_read_q <= 1'b0;
      rd_ack_q  <= 1'b0;
      cmd_ready <= 1'b1;
      rd_data   <= 8'h00;
      ack_o     <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      scl_o     <= 1'b1;
      sda_o     <= 1'b1;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            cnt_q     <= '0;
            phase_q   <= '0;
            bit_q     <= '0;
            data_q    <= wr_data;
            is_read_q <= (cmd == CmdRead);
            rd_ack_q  <= rd_ack;
            if (cmd == CmdStart) begin
              state_q        <= StStart;
              {scl_o, sda_o} <= phase_lines(StStart, 2'd0, scl_o, sda_o, 1'b1);
            end else if (!busy) begin
              state_q <= StErr;
            end else if (cmd == CmdStop) begin
              state_q        <= StStop;
              {scl_o, sda_o} <= phase_lines(StStop, 2'd0, scl_o, sda_o, 1'b1);
            end else begin
              state_q        <= StBit;
              {scl_o, sda_o} <= phase_lines(StBit, 2'd0, scl_o, sda_o,
                                            (cmd == CmdRead) | wr_data[7]);
            end
          end
        end
        StErr: begin
          // First cycle raises done/err, second returns to idle so ready follows done.
          if (!err) begin
            done <= 1'b1;
            err  <= 1'b1;
          end else begin
            state_q   <= StIdle;
            cmd_ready <= 1'b1;
          end
        end
        default: begin
          if (pre_done) begin
            done <= 1'b1;
            if (state_q == StStart) busy <= 1'b1;
            else if (state_q == StStop) busy <= 1'b0;
          end
          if (!stall) begin
            if (!tick) begin
              cnt_q <= cnt_q + CntW'(1);
            end else begin
              cnt_q <= '0;
              if (phase_q == 2'd1) begin
                if ((state_q == StBit) && is_read_q) rd_data <= {rd_data[6:0], sda_i};
                if ((state_q == StAck) && !is_read_q) ack_o <= ~sda_i;
              end
              if (phase_q != 2'd3) begin
                phase_q        <= phase_q + 2'd1;
                {scl_o, sda_o} <= phase_lines(state_q, phase_q + 2'd1, scl_o, sda_o, 1'b1);
              end else if (state_q == StBit) begin
                phase_q <= '0;
                data_q  <= {data_q[6:0], 1'b0};
                if (bit_q == 3'd7) begin
                  state_q        <= StAck;
                  {scl_o, sda_o} <= phase_lines(StAck, 2'd0, scl_o, sda_o,
                                                is_read_q ? ~rd_ack_q : 1'b1);
                end else begin
                  bit_q          <= bit_q + 3'd1;
                  {scl_o, sda_o} <= phase_lines(StBit, 2'd0, scl_o, sda_o,
                                                is_read_q | data_q[6]);
                end
              end else begin
                state_q   <= StIdle;
                cmd_ready <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

endmodule
